srt4_ctrl: RTL
==============

SRT4_CTRL -- requirements
Module: srt4_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, the datapath operand width (even, >= 4).
REQ-002 SHALL have port clk  in  1  the single clock, rising-edge active.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  in  1  request to begin one division.
REQ-005 SHALL have port m_msb  in  1  MSB of the divisor register.
REQ-006 SHALL have port p_top  in  4  top 4 bits of the partial remainder, two's complement.
REQ-007 SHALL have port p_sign  in  1  sign bit of the partial remainder.
REQ-008 SHALL have ports ld_a, ld_m  out  1  dividend/divisor register load strobes.
REQ-009 SHALL have port sh_norm  out  1  shift divisor and dividend left by 1.
REQ-010 SHALL have port sh2  out  1  shift remainder/quotient left by 2.
REQ-011 SHALL have ports add_en, sub_en, sel_2m  out  1  remainder add M, subtract M, and use 2M instead of M.
REQ-012 SHALL have ports ld_q  out  1 and q_digit  out  3  quotient digit strobe and value (two's complement, -2..+2).
REQ-013 SHALL have ports corr_en and denorm_en  out  1  sign correction and denormalize-by-k strobes.
REQ-014 SHALL have port k  out  clog2(W)  normalization shift count.
REQ-015 SHALL have ports busy and done  out  1  operation in progress, and one-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, LOAD, NORM, ITER, CORR, DENORM and DONE, one transition per clk.
REQ-017 SHALL move IDLE->LOAD when start=1, and SHALL ignore start in every other state.
REQ-018 LOAD SHALL assert ld_a and ld_m for 1 cycle, clear k and the iteration counter, then go to NORM.
REQ-019 NORM SHALL, each cycle with m_msb=0 and k<W-1, assert sh_norm and increment k; otherwise it SHALL go to ITER without shifting (k+1 cycles total).
REQ-020 ITER SHALL last exactly W/2 cycles, asserting sh2 and ld_q every cycle.
REQ-021 ITER SHALL select the digit from p_top as follows: >=+2 -> +2; +1 -> +1; 0 or -1 -> 0; -2 -> -1; <=-3 -> -2.
REQ-022 ITER SHALL set sub_en=1 for q>0, add_en=1 for q<0, and sel_2m=1 for |q|=2; for q=0, add_en, sub_en and sel_2m SHALL all be 0.
REQ-023 CORR SHALL last 1 cycle and assert corr_en iff p_sign=1.
REQ-024 DENORM SHALL last 1 cycle and assert denorm_en, with k held stable.
REQ-025 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-026 busy SHALL be 1 in LOAD through DENORM and 0 in IDLE and DONE.
REQ-027 Latency SHALL be: done high in cycle W/2+5+k after the edge that samples start.
REQ-028 Strobes SHALL be 0 in every state that does not name them.
REQ-029 k SHALL saturate at W-1 and never wrap.

Reset
REQ-030 When rst=1 at a clk edge, the state SHALL become IDLE, and k, the counter and every output SHALL become 0.
REQ-031 rst SHALL override start on the same edge and SHALL abort any state mid-operation, with no further strobes issued.

Configuration
REQ-032 With macro SRT4_DIVZERO_EN defined, the block SHALL add port m_zero (in 1, divisor is zero) and port dz (out 1, divide-by-zero flag).
REQ-033 With SRT4_DIVZERO_EN defined, m_zero=1 in the first NORM cycle SHALL cause NORM->DONE with no sh_norm, and dz=1 for that DONE cycle only.
REQ-034 With SRT4_DIVZERO_EN undefined, those ports SHALL be absent; an all-zero divisor SHALL take W-1 normalization shifts and complete normally, with an undefined result.

Verification
REQ-035 Bench SHALL cover: W=8, start with m_msb=1 -> k=0, ld_q high 4 cycles, done in cycle 9, busy low after.
REQ-036 Bench SHALL cover: m_msb=0 for 3 NORM cycles then 1 -> 3 sh_norm pulses, k=3, denorm_en with k=3, done in cycle 12.
REQ-037 Bench SHALL cover: p_top swept over -8..+7 during ITER -> q_digit, add_en, sub_en and sel_2m match the REQ-021/REQ-022 table for every value.
REQ-038 Bench SHALL cover: p_sign=1 in CORR -> corr_en=1 for 1 cycle; p_sign=0 -> corr_en=0.
REQ-039 Bench SHALL cover: rst=1 in the 2nd ITER cycle, then start held high during busy -> all outputs 0 next cycle, IDLE, and start re-accepted only from IDLE.
REQ-040 Bench SHALL cover, with SRT4_DIVZERO_EN defined: m_zero=1 -> no sh2, done and dz high in cycle 3.

Source files
------------

// File: rtl/srt4_ctrl_if.sv
// Signal bundle between the SRT radix-4 divider controller (master) and its datapath (slave).
// The divide-by-zero pair m_zero/dz exists only when SRT4_DIVZERO_EN is defined.
interface srt4_ctrl_if #(
    parameter int W = 8
);
    localparam int KW = $clog2(W);

    logic          start;
    logic          m_msb;
    logic [3:0]    p_top;
    logic          p_sign;
    logic          ld_a;
    logic          ld_m;
    logic          sh_norm;
    logic          sh2;
    logic          add_en;
    logic          sub_en;
    logic          sel_2m;
    logic          ld_q;
    logic [2:0]    q_digit;
    logic          corr_en;
    logic          denorm_en;
    logic [KW-1:0] k;
    logic          busy;
    logic          done;
`ifdef SRT4_DIVZERO_EN
    logic          m_zero;
    logic          dz;
`endif

    modport master (
        input  start, m_msb, p_top, p_sign,
`ifdef SRT4_DIVZERO_EN
        input  m_zero,
        output dz,
`endif
        output ld_a, ld_m, sh_norm, sh2, add_en, sub_en, sel_2m,
        output ld_q, q_digit, corr_en, denorm_en, k, busy, done
    );

    modport slave (
        output start, m_msb, p_top, p_sign,
`ifdef SRT4_DIVZERO_EN
        output m_zero,
        input  dz,
`endif
        input  ld_a, ld_m, sh_norm, sh2, add_en, sub_en, sel_2m,
        input  ld_q, q_digit, corr_en, denorm_en, k, busy, done
    );
endinterface

// File: rtl/srt4_ctrl.sv
// Sequencing FSM for an SRT radix-4 divider: load, normalize, W/2 digit iterations, correct, denormalize.
// Optional divide-by-zero early exit is enabled by defining SRT4_DIVZERO_EN.
module srt4_ctrl #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    srt4_ctrl_if.master bus
);
    localparam int KW = $clog2(W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_NORM   = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_CORR   = 3'd4;
    localparam logic [2:0] S_DENORM = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [KW-1:0] K_ZERO    = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE     = KW'(1);
    localparam logic [KW-1:0] K_MAX     = KW'(W - 1);
    localparam logic [KW-1:0] ITER_LAST = KW'(W / 2 - 1);

    logic [2:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          div_zero_s;
    logic          norm_shift_s;
    logic [2:0]    digit_s;

    // Quotient digit from the truncated remainder estimate, two's complement -2..+2.
    function automatic logic [2:0] sel_digit(input logic [3:0] p);
        logic signed [3:0] ps;
        ps = signed'(p);
        if (ps >= 4'sd2)         sel_digit = 3'b010;
        else if (ps == 4'sd1)    sel_digit = 3'b001;
        else if (ps >= -4'sd1)   sel_digit = 3'b000;
        else if (ps == -4'sd2)   sel_digit = 3'b111;
        else                     sel_digit = 3'b110;
    endfunction

`ifdef SRT4_DIVZERO_EN
    logic dz_q, dz_d;
    // k is still zero only in the first NORM cycle, which is where a zero divisor is trapped.
    assign div_zero_s = (state_q == S_NORM) && bus.m_zero && (k_q == K_ZERO);
    assign dz_d       = div_zero_s;
`else
    assign div_zero_s = 1'b0;
`endif

    assign norm_shift_s = (state_q == S_NORM) && !bus.m_msb && (k_q != K_MAX) && !div_zero_s;
    assign digit_s      = sel_digit(bus.p_top);
    assign bus.k        = k_q;

    // Next-state, normalization count and iteration count.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD;
                else           state_d = S_IDLE;
            end
            S_LOAD: begin
                k_d     = K_ZERO;
                cnt_d   = K_ZERO;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (div_zero_s)        state_d = S_DONE;
                else if (norm_shift_s) k_d     = k_q + K_ONE;
                else                   state_d = S_ITER;
            end
            S_ITER: begin
                cnt_d = cnt_q + K_ONE;
                if (cnt_q == ITER_LAST) state_d = S_CORR;
                else                    state_d = S_ITER;
            end
            S_CORR:   state_d = S_DENORM;
            S_DENORM: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobe decode: each strobe is zero outside the state that owns it.
    always_comb begin
        bus.ld_a      = 1'b0;
        bus.ld_m      = 1'b0;
        bus.sh_norm   = 1'b0;
        bus.sh2       = 1'b0;
        bus.add_en    = 1'b0;
        bus.sub_en    = 1'b0;
        bus.sel_2m    = 1'b0;
        bus.ld_q      = 1'b0;
        bus.q_digit   = 3'b000;
        bus.corr_en   = 1'b0;
        bus.denorm_en = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
`ifdef SRT4_DIVZERO_EN
        bus.dz        = 1'b0;
`endif
        case (state_q)
            S_IDLE: bus.busy = 1'b0;
            S_LOAD: begin
                bus.ld_a = 1'b1;
                bus.ld_m = 1'b1;
                bus.busy = 1'b1;
            end
            S_NORM: begin
                bus.sh_norm = norm_shift_s;
                bus.busy    = 1'b1;
            end
            S_ITER: begin
                bus.sh2     = 1'b1;
                bus.ld_q    = 1'b1;
                bus.q_digit = digit_s;
                bus.add_en  = digit_s[2];
                bus.sub_en  = !digit_s[2] && (digit_s != 3'b000);
                bus.sel_2m  = (digit_s == 3'b010) || (digit_s == 3'b110);
                bus.busy    = 1'b1;
            end
            S_CORR: begin
                bus.corr_en = bus.p_sign;
                bus.busy    = 1'b1;
            end
            S_DENORM: begin
                bus.denorm_en = 1'b1;
                bus.busy      = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
`ifdef SRT4_DIVZERO_EN
                bus.dz   = dz_q;
`endif
            end
            default: bus.busy = 1'b0;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= K_ZERO;
            cnt_q   <= K_ZERO;
`ifdef SRT4_DIVZERO_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
`ifdef SRT4_DIVZERO_EN
            dz_q    <= dz_d;
`endif
        end
    end
endmodule
